// File: rtl/usart_line_buffer.sv
// Purpose: assembles one CR-terminated text line from USART receive bytes, with backspace editing and random-access readout.
// Latency: buffer/length update 1 cycle after rx_valid; echo_valid 1 cycle after rx_valid; rd_data 1 cycle after rd_addr.
// Backpressure: echo holds echo_data stable until echo_ready; bytes arriving during echo or while a line is pending are dropped and flagged in overflow.
// Optional feature macro: USART_LINE_ECHO_EN (defined: edited characters are echoed back to the transmitter).
module usart_line_buffer #(
  parameter int DEPTH     = 64,
  parameter int ADDR_BITS = 6
) (
  input  logic                 comm_clock,
  input  logic                 reset_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           echo_data,
  output logic                 echo_valid,
  input  logic                 echo_ready,
  output logic                 line_ready,
  output logic [ADDR_BITS:0]   line_length,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [7:0]           rd_data,
  input  logic                 line_ack,
  output logic                 overflow
);

  localparam logic [ADDR_BITS:0] LP_DEPTH   = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0] LP_LEN_ONE = (ADDR_BITS + 1)'(1);

  // Byte classes seen on the receive side
  localparam logic [7:0] LP_BS  = 8'h08;
  localparam logic [7:0] LP_DEL = 8'h7F;
  localparam logic [7:0] LP_CR  = 8'h0D;
  localparam logic [7:0] LP_LF  = 8'h0A;
  localparam logic [7:0] LP_SP  = 8'h20;
  localparam logic [7:0] LP_TLD = 8'h7E;

`ifdef USART_LINE_ECHO_EN
  typedef enum logic [1:0] {
    ST_COLLECT    = 2'd0,
    ST_ECHO       = 2'd1,
    ST_LINE_READY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_COLLECT    = 2'd0,
    ST_LINE_READY = 2'd2
  } state_t;
`endif

  state_t             r_state;
  logic [ADDR_BITS:0] r_len;
  logic               r_overflow;
  logic               r_line_ready;
  logic [7:0]         r_rd_data;
  logic [7:0]         r_buf [DEPTH];

`ifdef USART_LINE_ECHO_EN
  // Echo sequencer: r_echo_data is the byte on offer, r_echo_nxt0/1 queue
  // the remaining bytes, r_echo_rem counts how many of them are still due.
  logic       r_echo_valid;
  logic [7:0] r_echo_data;
  logic [7:0] r_echo_nxt0;
  logic [7:0] r_echo_nxt1;
  logic [1:0] r_echo_rem;
  logic       r_echo_to_lr;
`else
  // The transmitter handshake has no meaning without echo; sink it here.
  logic w_unused_echo_ready;
  assign w_unused_echo_ready = echo_ready;
`endif

  logic w_is_print;
  logic w_is_bs;
  logic w_is_cr;
  logic w_has_room;
  logic w_buf_we;

  assign w_is_print = (rx_data >= LP_SP) && (rx_data <= LP_TLD);
  assign w_is_bs    = (rx_data == LP_BS) || (rx_data == LP_DEL);
  assign w_is_cr    = (rx_data == LP_CR);
  assign w_has_room = (r_len < LP_DEPTH);

  // Only printable bytes accepted while collecting ever reach the RAM
  assign w_buf_we = (r_state == ST_COLLECT) && rx_valid && w_is_print && w_has_room;

  // Line RAM write port; contents are deliberately left unreset
  always_ff @(posedge comm_clock) begin
    if (w_buf_we) begin
      r_buf[r_len[ADDR_BITS-1:0]] <= rx_data;
    end
  end

  // Registered readout port, independent of the line state
  always_ff @(posedge comm_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data <= 8'h00;
    end else begin
      r_rd_data <= r_buf[rd_addr];
    end
  end

  // Line-assembly state machine: classify bytes, edit the line, sequence echoes, hand off the line
  always_ff @(posedge comm_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_COLLECT;
      r_len        <= '0;
      r_overflow   <= 1'b0;
      r_line_ready <= 1'b0;
`ifdef USART_LINE_ECHO_EN
      r_echo_valid <= 1'b0;
      r_echo_data  <= 8'h00;
      r_echo_nxt0  <= 8'h00;
      r_echo_nxt1  <= 8'h00;
      r_echo_rem   <= 2'd0;
      r_echo_to_lr <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (rx_valid) begin
            if (w_is_print) begin
              if (w_has_room) begin
                r_len <= r_len + LP_LEN_ONE;
`ifdef USART_LINE_ECHO_EN
                r_state      <= ST_ECHO;
                r_echo_valid <= 1'b1;
                r_echo_data  <= rx_data;
                r_echo_rem   <= 2'd0;
                r_echo_to_lr <= 1'b0;
`endif
              end else begin
                // Line is full: the byte is lost and nothing is echoed
                r_overflow <= 1'b1;
              end
            end else if (w_is_bs) begin
              // Backspace on an empty line is silently ignored
              if (r_len != '0) begin
                r_len <= r_len - LP_LEN_ONE;
`ifdef USART_LINE_ECHO_EN
                // Rub out on the terminal: step back, blank, step back
                r_state      <= ST_ECHO;
                r_echo_valid <= 1'b1;
                r_echo_data  <= LP_BS;
                r_echo_nxt0  <= LP_SP;
                r_echo_nxt1  <= LP_BS;
                r_echo_rem   <= 2'd2;
                r_echo_to_lr <= 1'b0;
`endif
              end
            end else if (w_is_cr) begin
`ifdef USART_LINE_ECHO_EN
              // Line completes only once CR LF has gone out
              r_state      <= ST_ECHO;
              r_echo_valid <= 1'b1;
              r_echo_data  <= LP_CR;
              r_echo_nxt0  <= LP_LF;
              r_echo_rem   <= 2'd1;
              r_echo_to_lr <= 1'b1;
`else
              r_state      <= ST_LINE_READY;
              r_line_ready <= 1'b1;
`endif
            end
            // LF and every other control byte fall through untouched
          end
        end

`ifdef USART_LINE_ECHO_EN
        ST_ECHO: begin
          // The receiver cannot be paused, so anything arriving now is lost
          if (rx_valid) begin
            r_overflow <= 1'b1;
          end
          if (echo_ready) begin
            if (r_echo_rem != 2'd0) begin
              r_echo_data <= r_echo_nxt0;
              r_echo_nxt0 <= r_echo_nxt1;
              r_echo_rem  <= r_echo_rem - 2'd1;
            end else begin
              r_echo_valid <= 1'b0;
              r_echo_data  <= 8'h00;
              r_echo_to_lr <= 1'b0;
              if (r_echo_to_lr) begin
                r_state      <= ST_LINE_READY;
                r_line_ready <= 1'b1;
              end else begin
                r_state <= ST_COLLECT;
              end
            end
          end
        end
`endif

        ST_LINE_READY: begin
          // Acknowledge takes priority over a coincident receive byte
          if (line_ack) begin
            r_len        <= '0;
            r_overflow   <= 1'b0;
            r_line_ready <= 1'b0;
            r_state      <= ST_COLLECT;
          end else if (rx_valid) begin
            r_overflow <= 1'b1;
          end
        end

        default: begin
          r_state      <= ST_COLLECT;
          r_line_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef USART_LINE_ECHO_EN
  assign echo_valid = r_echo_valid;
  assign echo_data  = r_echo_data;
`else
  assign echo_valid = 1'b0;
  assign echo_data  = 8'h00;
`endif

  assign line_ready  = r_line_ready;
  assign line_length = r_len;
  assign rd_data     = r_rd_data;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_usart_line_buffer.sv
// Bench for usart_line_buffer: a queue-based line model predicts echo bytes,
// completed-line records and readout data; monitors pop and compare them.
module tb_usart_line_buffer;

  localparam int DEPTH = 4;
  localparam int AB    = 2;
`ifdef USART_LINE_ECHO_EN
  localparam bit ECHO_EN = 1'b1;
`else
  localparam bit ECHO_EN = 1'b0;
`endif

  logic          comm_clock = 1'b0;
  logic          reset_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    echo_data;
  logic          echo_valid;
  logic          echo_ready;
  logic          line_ready;
  logic [AB:0]   line_length;
  logic [AB-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          line_ack;
  logic          overflow;

  usart_line_buffer #(.DEPTH(DEPTH), .ADDR_BITS(AB)) dut (
    .comm_clock (comm_clock),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .echo_data  (echo_data),
    .echo_valid (echo_valid),
    .echo_ready (echo_ready),
    .line_ready (line_ready),
    .line_length(line_length),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .line_ack   (line_ack),
    .overflow   (overflow)
  );

  always #5 comm_clock = ~comm_clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the line as a byte queue plus the sticky drop flag
  logic [7:0] m_line[$];
  bit         m_ovf;

  // Scoreboard queues
  logic [7:0] exp_echo[$];
  logic [7:0] exp_rd[$];
  int         exp_len[$];
  bit         exp_ovf[$];

  int   ready_mode = 0;   // 0 random, 1 held low, 2 held high
  logic rd_req = 1'b0;
  logic rd_req_d = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_note(input string nm, input int info);
    n_vec++;
    n_err++;
    $display("FAIL %s: info %0d at %0t", nm, info, $time);
  endtask

  // Specification-level effect of one received byte while collecting
  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      if (m_line.size() < DEPTH) begin
        m_line.push_back(b);
        if (ECHO_EN) exp_echo.push_back(b);
      end else begin
        m_ovf = 1'b1;
      end
    end else if (b == 8'h08 || b == 8'h7F) begin
      if (m_line.size() > 0) begin
        void'(m_line.pop_back());
        if (ECHO_EN) begin
          exp_echo.push_back(8'h08);
          exp_echo.push_back(8'h20);
          exp_echo.push_back(8'h08);
        end
      end
    end else if (b == 8'h0D) begin
      if (ECHO_EN) begin
        exp_echo.push_back(8'h0D);
        exp_echo.push_back(8'h0A);
      end
      exp_len.push_back(m_line.size());
      exp_ovf.push_back(m_ovf);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge comm_clock); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge comm_clock); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_echo.size() != 0 && t < 400) begin
      @(negedge comm_clock);
      t++;
    end
    if (exp_echo.size() != 0) begin
      fail_note("echo_drain_timeout", exp_echo.size());
      exp_echo.delete();
    end
  endtask

  task automatic feed(input logic [7:0] b);
    model_byte(b);
    send_byte(b);
`ifndef USART_LINE_ECHO_EN
    if (b == 8'h0D) begin
      @(negedge comm_clock);
      chk("line_ready_after_cr", 32'(line_ready), 32'd1);
    end
`endif
    wait_drain();
    repeat ($urandom_range(0, 2)) @(posedge comm_clock);
  endtask

  // Wait for the line, read it out, optionally provoke a drop, then acknowledge
  task automatic finish_line(input bit drop, input bit ack_rx);
    int t = 0;
    while (line_ready !== 1'b1 && t < 300) begin
      @(negedge comm_clock);
      t++;
    end
    if (line_ready !== 1'b1) fail_note("line_ready_timeout", t);
    for (int i = 0; i < m_line.size(); i++) begin
      @(posedge comm_clock); #1;
      rd_addr = AB'(i);
      rd_req  = 1'b1;
      exp_rd.push_back(m_line[i]);
    end
    @(posedge comm_clock); #1;
    rd_req = 1'b0;
    if (drop) begin
      send_byte(8'h5A);
      m_ovf = 1'b1;
      @(negedge comm_clock);
      chk("overflow_drop_in_line_ready", 32'(overflow), 32'd1);
      chk("length_kept_in_line_ready", 32'(line_length), 32'(m_line.size()));
    end
    @(posedge comm_clock); #1;
    line_ack = 1'b1;
    if (ack_rx) begin
      rx_data  = 8'h41;
      rx_valid = 1'b1;
    end
    @(posedge comm_clock); #1;
    line_ack = 1'b0;
    rx_valid = 1'b0;
    m_line.delete();
    m_ovf = 1'b0;
    @(negedge comm_clock);
    chk("line_ready_after_ack", 32'(line_ready), 32'd0);
    chk("length_after_ack", 32'(line_length), 32'd0);
    chk("overflow_after_ack", 32'(overflow), 32'd0);
  endtask

  function automatic logic [7:0] rand_byte();
    int r = $urandom_range(0, 99);
    if (r < 60) return 8'($urandom_range(32, 126));
    if (r < 72) return ($urandom_range(0, 1) == 0) ? 8'h08 : 8'h7F;
    if (r < 80) return 8'h0A;
    if (r < 90) return 8'($urandom_range(0, 31)) & 8'h17;
    return 8'($urandom_range(128, 255));
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_echo_valid"}, 32'(echo_valid), 32'd0);
    chk({tag, "_echo_data"}, 32'(echo_data), 32'd0);
    chk({tag, "_line_ready"}, 32'(line_ready), 32'd0);
    chk({tag, "_line_length"}, 32'(line_length), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  // Transmitter-side ready driver
  initial begin
    echo_ready = 1'b0;
    forever begin
      @(posedge comm_clock); #1;
      case (ready_mode)
        1:       echo_ready = 1'b0;
        2:       echo_ready = 1'b1;
        default: echo_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  always @(posedge comm_clock) rd_req_d <= rd_req;

  // Monitor: echo stream, hold-while-stalled, line hand-off, readout data
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  bit         lr_prev = 1'b0;
  bit         expect_lr = 1'b0;
  always @(negedge comm_clock) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
      lr_prev    = 1'b0;
      expect_lr  = 1'b0;
    end else begin
`ifdef USART_LINE_ECHO_EN
      if (expect_lr) begin
        chk("line_ready_after_lf", 32'(line_ready), 32'd1);
        expect_lr = 1'b0;
      end
      if (prev_stall) begin
        chk("echo_hold_valid", 32'(echo_valid), 32'd1);
        chk("echo_hold_data", 32'(echo_data), 32'(prev_data));
      end
      if (echo_valid && echo_ready) begin
        if (exp_echo.size() == 0) begin
          fail_note("echo_unexpected_byte", int'(echo_data));
        end else begin
          logic [7:0] e;
          e = exp_echo.pop_front();
          chk("echo_data", 32'(echo_data), 32'(e));
          if (e == 8'h0A) expect_lr = 1'b1;
        end
      end
      prev_stall = echo_valid && !echo_ready;
      prev_data  = echo_data;
`else
      chk("echo_valid_off", 32'(echo_valid), 32'd0);
      chk("echo_data_off", 32'(echo_data), 32'd0);
`endif
      if (line_ready && !lr_prev) begin
        if (exp_len.size() == 0) begin
          fail_note("line_ready_unexpected", int'(line_length));
        end else begin
          int  l;
          bit  o;
          l = exp_len.pop_front();
          o = exp_ovf.pop_front();
          chk("line_length", 32'(line_length), 32'(l));
          chk("line_overflow", 32'(overflow), 32'(o));
        end
      end
      lr_prev = line_ready;
      if (rd_req_d) begin
        if (exp_rd.size() == 0) begin
          fail_note("rd_unexpected", int'(rd_data));
        end else begin
          logic [7:0] d;
          d = exp_rd.pop_front();
          chk("rd_data", 32'(rd_data), 32'(d));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    rd_addr  = '0;
    line_ack = 1'b0;
    m_ovf    = 1'b0;
    repeat (3) @(negedge comm_clock);
    check_reset_vals("reset");
    @(posedge comm_clock); #1;
    reset_n = 1'b1;

    // "AB" CR with the transmitter always ready
    ready_mode = 2;
    feed(8'h41); feed(8'h42); feed(8'h0D);
    finish_line(1'b0, 1'b0);

    // Editing: "ABC" BS "D" CR gives "ABD"
    ready_mode = 0;
    feed(8'h41); feed(8'h42); feed(8'h43); feed(8'h08); feed(8'h44); feed(8'h0D);
    finish_line(1'b0, 1'b0);

    // DEL on an empty line, LF ignored, empty line is valid
    feed(8'h7F); feed(8'h0A); feed(8'h0D);
    finish_line(1'b0, 1'b0);

    // Overflow: "ABCDE" into a 4-byte line, then ack with a coincident byte
    feed(8'h41); feed(8'h42); feed(8'h43); feed(8'h44); feed(8'h45); feed(8'h0D);
    finish_line(1'b1, 1'b1);

`ifdef USART_LINE_ECHO_EN
    // Stalled transmitter: 'X' held for 20 cycles, a byte arriving meanwhile is dropped
    ready_mode = 1;
    model_byte(8'h58);
    send_byte(8'h58);
    for (int i = 0; i < 20; i++) begin
      @(negedge comm_clock);
      chk("stall_echo_valid", 32'(echo_valid), 32'd1);
      chk("stall_echo_data", 32'(echo_data), 32'h58);
    end
    m_ovf = 1'b1;
    send_byte(8'h41);
    @(negedge comm_clock);
    chk("overflow_drop_in_echo", 32'(overflow), 32'd1);
    chk("length_drop_in_echo", 32'(line_length), 32'd1);
    ready_mode = 0;
    wait_drain();

    // A byte coinciding with the final echo transfer is still dropped
    ready_mode = 1;
    model_byte(8'h59);
    send_byte(8'h59);
    ready_mode = 2;
    send_byte(8'h42);
    ready_mode = 0;
    @(negedge comm_clock);
    chk("overflow_drop_at_last_echo", 32'(overflow), 32'd1);
    chk("length_drop_at_last_echo", 32'(line_length), 32'd2);
    wait_drain();
    feed(8'h0D);
    finish_line(1'b0, 1'b0);
`else
    // Without echo: "HI" CR
    feed(8'h48); feed(8'h49); feed(8'h0D);
    finish_line(1'b0, 1'b0);
`endif

    // Randomized lines
    for (int ln = 0; ln < 40; ln++) begin
      int nb;
      nb = $urandom_range(0, 7);
      ready_mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
      for (int k = 0; k < nb; k++) feed(rand_byte());
      feed(8'h0D);
      finish_line($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    // Reset in the middle of a line, possibly while an echo is stalled
    ready_mode = 0;
    feed(8'h41); feed(8'h42);
    ready_mode = 1;
    model_byte(8'h43);
    send_byte(8'h43);
    @(posedge comm_clock); #3;
    reset_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    exp_echo.delete();
    exp_len.delete();
    exp_ovf.delete();
    exp_rd.delete();
    m_line.delete();
    m_ovf = 1'b0;
    repeat (2) @(posedge comm_clock);
    ready_mode = 0;
    #1;
    reset_n = 1'b1;

    // Recovery after reset
    feed(8'h4F); feed(8'h4B); feed(8'h0D);
    finish_line(1'b0, 1'b0);

    repeat (4) @(posedge comm_clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
